// File: rtl/clock_generator_pkg.sv
// Shared constants and types for the programmable clock divider.
//
//   DivWDefault     default width of the divide ratio and counter
//   DefaultDivRatio ratio loaded at reset
//   MinDivRatio     smallest ratio honoured; smaller requests are clamped up to it
//   cg_state_e      run/idle state of the divider
package clock_generator_pkg;

    localparam int unsigned DivWDefault     = 8;
    localparam int unsigned DefaultDivRatio = 2;
    localparam int unsigned MinDivRatio     = 2;

    typedef enum logic {
        StIdle,
        StRun
    } cg_state_e;

endpackage

// File: rtl/clock_generator.sv
// Programmable clock divider producing the processor "clock" from the reference clk.
// The output is always register-driven: a rising-edge phase flop ANDed with a
// falling-edge duty-correction flop, giving 50% duty for both even and odd ratios.
//
// Ports
//   clk         reference clock; all state on the rising edge except the duty flop
//   rst_n       asynchronous active-low reset
//   en          run enable, sampled on the clk rising edge
//   div_ratio   requested ratio N (values below 2 act as 2)
//   clock       divided output clock
//   clock_rise  1-clk pulse in the clk cycle where clock rises
//   clock_fall  1-clk pulse in the clk cycle where clock falls
//   ratio_ack   1-clk pulse when a different ratio becomes the active ratio
module clock_generator
    import clock_generator_pkg::*;
#(
    parameter int unsigned DIV_W       = DivWDefault,
    parameter int unsigned DEFAULT_DIV = DefaultDivRatio
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_ratio,
    output logic             clock,
    output logic             clock_rise,
    output logic             clock_fall,
    output logic             ratio_ack
);

    localparam logic [DIV_W-1:0] RatioRst = (DEFAULT_DIV < MinDivRatio) ?
                                            DIV_W'(MinDivRatio) : DIV_W'(DEFAULT_DIV);
    // Duty flop idles high for even ratios so the output follows the phase flop directly.
    localparam logic NegRst = ~RatioRst[0];

    function automatic logic [DIV_W-1:0] clamp_ratio(input logic [DIV_W-1:0] r);
        return (r < DIV_W'(MinDivRatio)) ? DIV_W'(MinDivRatio) : r;
    endfunction

    // Number of counts the phase flop is high: ceil(N/2), computed without overflow.
    function automatic logic [DIV_W-1:0] high_counts(input logic [DIV_W-1:0] n);
        return (n >> 1) + {{(DIV_W-1){1'b0}}, n[0]};
    endfunction

    cg_state_e        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] ratio_q, ratio_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             ack_q, ack_d;
    logic             neg_q;

    logic [DIV_W-1:0] cnt_last;
    logic [DIV_W-1:0] cnt_adv;
    logic             at_last;
    logic             high_adv;
    logic             park;
    logic             next_odd;

    // Counter advance shared by the FSM and datapath.
    always_comb begin
        cnt_last = ratio_q - DIV_W'(1);
        at_last  = (cnt_q == cnt_last);
        cnt_adv  = at_last ? '0 : cnt_q + DIV_W'(1);
        // At a wrap cnt_adv is 0, which is high for any ratio.
        high_adv = (cnt_adv < high_counts(ratio_q));
        // With en low, only an unfinished high phase keeps the counter running.
        park     = !en && !(clk_q && high_adv);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (en) state_d = StRun;
            StRun:   if (park) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state.
    always_comb begin
        cnt_d   = cnt_q;
        ratio_d = ratio_q;
        pend_d  = pend_q;
        clk_d   = clk_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        ack_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                clk_d = 1'b0;
                if (en) begin
                    clk_d  = 1'b1;
                    rise_d = 1'b1;
                end
            end
            StRun: begin
                if (park) begin
                    cnt_d  = '0;
                    clk_d  = 1'b0;
                    fall_d = clk_q;
                end else begin
                    cnt_d  = cnt_adv;
                    clk_d  = high_adv;
                    rise_d = at_last;
                    fall_d = clk_q & ~high_adv;
                    // Capture the request as the final count begins so its parity is
                    // known to the duty flop before the wrap that applies it.
                    if (cnt_adv == cnt_last) begin
                        pend_d = clamp_ratio(div_ratio);
                    end
                    if (at_last) begin
                        ratio_d = pend_q;
                        ack_d   = (pend_q != ratio_q);
                    end
                end
            end
            default: begin
                cnt_d = '0;
                clk_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            ratio_q <= RatioRst;
            pend_q  <= RatioRst;
            clk_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ratio_q <= ratio_d;
            pend_q  <= pend_d;
            clk_q   <= clk_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            ack_q   <= ack_d;
        end
    end

    // Parity of the ratio governing the next rising edge: during the final count that is
    // the pending ratio, otherwise the active one.
    always_comb begin
        next_odd = (state_q == StRun && at_last) ? pend_q[0] : ratio_q[0];
    end

    // Duty-correction flop: for odd ratios it delays the rise by half a clk period, so the
    // AND below is high for exactly N/2 periods; for even ratios it holds high.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= NegRst;
        end else begin
            neg_q <= next_odd ? clk_q : 1'b1;
        end
    end

    // Outputs: flop-only paths, no combinational route from clk.
    always_comb begin
        clock      = clk_q & neg_q;
        clock_rise = rise_q;
        clock_fall = fall_q;
        ratio_ack  = ack_q;
    end

endmodule

// File: tb/tb_clock_generator.sv
// Directed self-checking bench for clock_generator. The reference clk has a period of
// 10 time units, so an N-ratio output has period 10*N and high time 5*N.
module tb_clock_generator;

    localparam int unsigned Bound = 3000;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] div_ratio;
    logic       clock;
    logic       clock_rise;
    logic       clock_fall;
    logic       ratio_ack;

    int unsigned n_checks;
    int unsigned n_errors;

    time         last_rise;
    time         last_fall;
    int unsigned n_rise;
    int unsigned n_fall;
    int unsigned n_rstb;
    int unsigned n_fstb;
    int unsigned n_ack;

    clock_generator #(
        .DIV_W      (8),
        .DEFAULT_DIV(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .div_ratio (div_ratio),
        .clock     (clock),
        .clock_rise(clock_rise),
        .clock_fall(clock_fall),
        .ratio_ack (ratio_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        last_rise = 0;
        last_fall = 0;
        n_rise    = 0;
        n_fall    = 0;
        n_rstb    = 0;
        n_fstb    = 0;
        n_ack     = 0;
    end

    always @(posedge clock) begin
        last_rise <= $time;
        n_rise    <= n_rise + 1;
    end

    always @(negedge clock) begin
        last_fall <= $time;
        n_fall    <= n_fall + 1;
    end

    always @(negedge clk) begin
        if (clock_rise) n_rstb <= n_rstb + 1;
        if (clock_fall) n_fstb <= n_fstb + 1;
        if (ratio_ack)  n_ack  <= n_ack + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rise(input string tag);
        int unsigned base = n_rise;
        int unsigned k = 0;
        while (n_rise == base && k < Bound) begin
            #1;
            k++;
        end
        check({tag, "_rise_seen"}, 32'(n_rise != base), 1);
    endtask

    task automatic wait_fall(input string tag);
        int unsigned base = n_fall;
        int unsigned k = 0;
        while (n_fall == base && k < Bound) begin
            #1;
            k++;
        end
        check({tag, "_fall_seen"}, 32'(n_fall != base), 1);
    endtask

    task automatic wait_ack(input string tag);
        int unsigned base = n_ack;
        int unsigned k = 0;
        while (n_ack == base && k < Bound) begin
            #1;
            k++;
        end
        check({tag, "_ack_seen"}, 32'(n_ack != base), 1);
    endtask

    // Measures the period whose rising edge was the most recent one.
    task automatic measure_cur(input string tag, input int unsigned exp_per,
                               input int unsigned exp_hi);
        time t0;
        int unsigned hi;
        int unsigned per;
        t0 = last_rise;
        wait_fall(tag);
        hi = 32'(last_fall - t0);
        wait_rise(tag);
        per = 32'(last_rise - t0);
        check({tag, "_high"}, hi, exp_hi);
        check({tag, "_period"}, per, exp_per);
    endtask

    // Counts clk cycles between consecutive clock_rise strobes and the falls in between.
    task automatic rise_gap(input string tag, input int unsigned exp_gap);
        int unsigned k = 0;
        int unsigned falls = 0;
        int unsigned both = 0;
        while (!clock_rise && k < Bound) begin
            tick(1);
            k++;
        end
        k = 0;
        do begin
            tick(1);
            k++;
            if (clock_fall) falls++;
            if (clock_fall && clock_rise) both++;
        end while (!clock_rise && k < Bound);
        check({tag, "_gap"}, k, exp_gap);
        check({tag, "_falls"}, falls, 1);
        check({tag, "_excl"}, both, 0);
    endtask

    initial begin
        int unsigned ack_base;
        int unsigned rs_base;
        int unsigned fs_base;
        n_checks  = 0;
        n_errors  = 0;

        // 1. Reset state and first-edge latency.
        rst_n     = 1'b0;
        en        = 1'b1;
        div_ratio = 8'd2;
        tick(3);
        check("rst_clock", 32'(clock), 0);
        check("rst_rise", 32'(clock_rise), 0);
        check("rst_fall", 32'(clock_fall), 0);
        check("rst_ack", 32'(ratio_ack), 0);
        rst_n = 1'b1;
        tick(1);
        check("start_clock", 32'(clock), 1);
        check("start_rise", 32'(clock_rise), 1);
        tick(1);
        check("n2_low_clock", 32'(clock), 0);
        check("n2_low_fall", 32'(clock_fall), 1);
        check("n2_low_rise", 32'(clock_rise), 0);

        // 2. N=2.
        wait_rise("n2");
        measure_cur("n2", 20, 10);
        rise_gap("n2", 2);

        // 3. N=5, odd duty.
        div_ratio = 8'd5;
        wait_rise("n5a");
        measure_cur("n5a", 50, 25);
        measure_cur("n5b", 50, 25);
        rise_gap("n5", 5);

        // 4. N=4, then 6 requested mid-high.
        div_ratio = 8'd4;
        wait_ack("n4");
        check("n4_clock_high", 32'(clock), 1);
        div_ratio = 8'd6;
        ack_base  = n_ack;
        measure_cur("n4_cur", 40, 20);
        measure_cur("n6_next", 60, 30);
        check("n6_ack_count", n_ack - ack_base, 1);

        // 5. en dropped one cycle into the high phase of N=6.
        tick(1);
        en = 1'b0;
        wait_fall("en_off");
        check("en_off_high", 32'(last_fall - last_rise), 30);
        tick(1);
        rs_base = n_rstb;
        fs_base = n_fstb;
        tick(10);
        check("en_off_clock", 32'(clock), 0);
        check("en_off_rstb", n_rstb - rs_base, 0);
        check("en_off_fstb", n_fstb - fs_base, 0);
        en = 1'b1;
        tick(1);
        check("en_on_clock", 32'(clock), 1);
        check("en_on_rise", 32'(clock_rise), 1);
        measure_cur("en_on", 60, 30);

        // 6. Asynchronous reset while high, then clamped ratios.
        check("pre_rst_clock", 32'(clock), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_clock", 32'(clock), 0);
        check("async_rst_rise", 32'(clock_rise), 0);
        check("async_rst_fall", 32'(clock_fall), 0);
        div_ratio = 8'd0;
        rst_n     = 1'b1;
        ack_base  = n_ack;
        tick(1);
        check("rerun_clock", 32'(clock), 1);
        check("rerun_rise", 32'(clock_rise), 1);
        wait_rise("div0");
        measure_cur("div0", 20, 10);
        div_ratio = 8'd1;
        wait_rise("div1");
        wait_rise("div1");
        measure_cur("div1", 20, 10);
        check("clamp_ack_count", n_ack - ack_base, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
